// File: rtl/spmv_result_writer.sv
// Streams a captured SpMV result vector into an M10K write port, one element per
// accepted write, with back-pressure from i_wr_ready and a one-cycle done pulse.
module spmv_result_writer #(
    parameter int N_ELEM    = 16,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    input  logic [N_ELEM*DATA_W-1:0] i_result_vec,
    input  logic                     i_wr_ready,
    output logic [ADDR_W-1:0]        o_write_addr,
    output logic [DATA_W-1:0]        o_write_data,
    output logic                     o_write_en,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int                IDX_W    = $clog2(N_ELEM) + 1;
    localparam int                VEC_W    = N_ELEM * DATA_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_ELEM - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [VEC_W-1:0]    r_shadow;
    logic [VEC_W-1:0]    w_shadow_shift;
    logic [ADDR_W-1:0]   r_write_addr;
    logic [DATA_W-1:0]   r_write_data;
    logic                r_write_en;
    logic                r_busy;
    logic                r_done;
    logic                w_accept;
    logic                w_last;

    assign w_accept       = r_write_en && i_wr_ready;
    assign w_last         = (r_idx == LAST_IDX);
    // Element idx always sits in the low slice; the next one is one shift away.
    assign w_shadow_shift = r_shadow >> DATA_W;

    assign o_write_addr = r_write_addr;
    assign o_write_data = r_write_data;
    assign o_write_en   = r_write_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_WRITE;
            S_WRITE: if (w_accept && w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // The first WRITE cycle primes the output registers (write enable still low),
    // so the first request appears one cycle after the shadow is captured.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_idx        <= '0;
            r_shadow     <= '0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_write_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy <= (w_next_state == S_LOAD) || (w_next_state == S_WRITE);
            r_done <= (w_next_state == S_DONE);
            case (r_state)
                S_LOAD: begin
                    r_shadow <= i_result_vec;
                    r_idx    <= '0;
                end
                S_WRITE: begin
                    if (!r_write_en) begin
                        r_write_en   <= 1'b1;
                        r_write_addr <= BASE_A;
                        r_write_data <= r_shadow[DATA_W-1:0];
                    end else if (i_wr_ready) begin
                        if (w_last) begin
                            r_write_en <= 1'b0;
                        end else begin
                            r_idx        <= r_idx + IDX_W'(1);
                            r_write_addr <= r_write_addr + ADDR_W'(1);
                            r_write_data <= w_shadow_shift[DATA_W-1:0];
                            r_shadow     <= w_shadow_shift;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_result_writer.sv
// Directed bench for spmv_result_writer: nominal, stall, address wrap, input
// isolation, reset abort and the single-element configuration.
module tb_spmv_result_writer;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic         ready;
    logic [255:0] vec;

    logic [9:0]   addr0, addr1, addr2;
    logic [15:0]  data0, data1, data2;
    logic         en0, en1, en2;
    logic         busy0, busy1, busy2;
    logic         done0, done1, done2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spmv_result_writer dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_result_vec(vec),
        .i_wr_ready(ready), .o_write_addr(addr0), .o_write_data(data0),
        .o_write_en(en0), .o_busy(busy0), .o_done(done0)
    );

    spmv_result_writer #(.BASE_ADDR(1020)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_result_vec(vec),
        .i_wr_ready(ready), .o_write_addr(addr1), .o_write_data(data1),
        .o_write_en(en1), .o_busy(busy1), .o_done(done1)
    );

    spmv_result_writer #(.N_ELEM(1), .BASE_ADDR(5)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_result_vec(vec[15:0]),
        .i_wr_ready(ready), .o_write_addr(addr2), .o_write_data(data2),
        .o_write_en(en2), .o_busy(busy2), .o_done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_nominal_vec();
        for (int k = 0; k < 16; k++) vec[k*16 +: 16] = 16'h1000 + 16'(k);
    endtask

    // Runs one dut0 job (and shadows dut1/dut2 when they share the nominal job).
    // mode 0: data 0x1000+k; mode 1: data 0xFFFF.
    task automatic run_job(input bit do_start, input bit hold_start, input bit chg_vec,
                           input int stall_len, input int mode);
        int n_wr0, n_wr1, n_wr2, done_cyc, start_cyc, stall_left, it;
        bit fin, d2_seen;
        bit chk_side;
        logic [15:0] exp_d;
        n_wr0 = 0; n_wr1 = 0; n_wr2 = 0; done_cyc = 0; start_cyc = 0;
        fin = 1'b0; d2_seen = 1'b0; it = 0;
        stall_left = stall_len;
        chk_side = do_start && !hold_start && (mode == 0);
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start_cyc = cyc;
            if (!hold_start) start = 1'b0;
        end
        while (!fin && it < 80) begin
            @(negedge clk);
            if (en0 && ready) begin
                exp_d = (mode == 0) ? (16'h1000 + n_wr0[15:0]) : 16'hFFFF;
                check("addr0", 32'(addr0), n_wr0);
                check("data0", 32'(data0), 32'(exp_d));
                n_wr0++;
            end
            if (en1 && ready) begin
                if (mode == 0) check("wrap_addr1", 32'(addr1), (1020 + n_wr1) % 1024);
                n_wr1++;
            end
            if (en2 && ready) begin
                if (chk_side) begin
                    check("addr2", 32'(addr2), 5);
                    check("data2", 32'(data2), 32'h1000);
                end
                n_wr2++;
            end
            if (done2 && chk_side && !d2_seen) begin
                d2_seen = 1'b1;
                check("lat2", cyc - start_cyc, 3);
            end
            if (!ready) begin
                check("stall_addr", 32'(addr0), 5);
                check("stall_data", 32'(data0), 32'h1005);
                check("stall_en", 32'(en0), 1);
            end
            if (done0) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            @(posedge clk); #1;
            if (chg_vec && it == 0) vec = '1;
            if (n_wr0 == 5 && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end else begin
                ready = 1'b1;
            end
            it++;
        end
        check("done_seen", 32'(fin), 1);
        check("nwr0", n_wr0, 16);
        if (do_start) check("latency", done_cyc - start_cyc, 18 + stall_len);
        if (chk_side) begin
            check("nwr1", n_wr1, 16);
            check("nwr2", n_wr2, 1);
            check("done2_seen", 32'(d2_seen), 1);
        end
        @(negedge clk);
        check("done_pulse", 32'(done0), 0);
        check("idle_busy", 32'(busy0), 0);
    endtask

    initial begin
        int nw, it;
        rstn = 1'b0; start = 1'b0; ready = 1'b1; vec = '0;
        set_nominal_vec();
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", {29'd0, en0, en1, en2}, 0);
        check("rst_busy", {29'd0, busy0, busy1, busy2}, 0);
        check("rst_done", {29'd0, done0, done1, done2}, 0);
        check("rst_addr0", 32'(addr0), 0);
        check("rst_data0", 32'(data0), 0);
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);

        // nominal job
        run_job(1'b1, 1'b0, 1'b0, 0, 0);

        // back-pressure at element 5
        run_job(1'b1, 1'b0, 1'b0, 3, 0);

        // isolation: vector overwritten after capture, start held high
        run_job(1'b1, 1'b1, 1'b1, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("restart_busy", 32'(busy0), 1);
        @(posedge clk); #1;
        start = 1'b0;
        run_job(1'b0, 1'b0, 1'b0, 0, 1);
        set_nominal_vec();
        repeat (6) @(negedge clk);

        // reset abort after the 7th accepted write
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nw = 0; it = 0;
        while (nw < 7 && it < 40) begin
            @(negedge clk);
            if (en0 && ready) nw++;
            if (nw < 7) begin
                @(posedge clk); #1;
            end
            it++;
        end
        check("abort_cnt", nw, 7);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("abort_en", 32'(en0), 0);
        check("abort_addr", 32'(addr0), 0);
        check("abort_data", 32'(data0), 0);
        check("abort_busy", 32'(busy0), 0);
        check("abort_done", 32'(done0), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_abort_idle", {29'd0, en0, busy0, done0}, 0);
        end

        // fresh job after abort
        run_job(1'b1, 1'b0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spmv_result_writer.md
SPMV_RESULT_WRITER -- requirements
Module: spmv_result_writer

Interface
REQ-001 Parameter N_ELEM, default 16, number of 16-bit result elements written per job.
REQ-002 Parameter DATA_W, default 16, width of one result element and of the memory write data.
REQ-003 Parameter ADDR_W, default 10, width of the M10K write address.
REQ-004 Parameter BASE_ADDR, default 0, M10K address of element 0.
REQ-005 One clock, i_clk; reset is asynchronous and active-low, i_rstn.
REQ-006 i_clk  input  1  rising-edge clock for all state.
REQ-007 i_rstn  input  1  asynchronous active-low reset.
REQ-008 i_start  input  1  job request, sampled only in IDLE.
REQ-009 i_result_vec  input  N_ELEM*DATA_W  result vector; element k occupies bits [k*DATA_W +: DATA_W].
REQ-010 i_wr_ready  input  1  M10K port grant; a write is accepted on a cycle with o_write_en=1 and i_wr_ready=1.
REQ-011 o_write_addr  output  ADDR_W  M10K write address.
REQ-012 o_write_data  output  DATA_W  M10K write data.
REQ-013 o_write_en  output  1  write request.
REQ-014 o_busy  output  1  high in LOAD and WRITE.
REQ-015 o_done  output  1  one-cycle completion pulse.

Function
REQ-016 States IDLE, LOAD, WRITE, DONE; all outputs registered.
REQ-017 IDLE: i_start=1 -> LOAD; otherwise stay.
REQ-018 LOAD: capture i_result_vec into an internal shadow register, clear element index to 0; -> WRITE unconditionally next cycle.
REQ-019 i_result_vec is sampled only in LOAD; later changes do not affect the job.
REQ-020 WRITE: o_write_en=1, o_write_addr=(BASE_ADDR+idx) mod 2^ADDR_W, o_write_data=shadow element idx.
REQ-021 Accepted write (i_wr_ready=1): idx increments, address/data advance the next cycle; i_wr_ready=0: address, data, o_write_en held unchanged (stall, no skip, no repeat).
REQ-022 Acceptance of element N_ELEM-1 -> DONE; o_write_en=0 from the next cycle.
REQ-023 DONE: o_done=1 for exactly one cycle, then -> IDLE.
REQ-024 Latency with i_wr_ready held 1: i_start sampled at edge 0; first write visible after edge 2; last write after edge N_ELEM+1; o_done after edge N_ELEM+2; IDLE after edge N_ELEM+3.
REQ-025 i_start is ignored in LOAD, WRITE, DONE; a start in the DONE cycle is not queued.
REQ-026 Address wrap: BASE_ADDR+idx overflowing ADDR_W wraps modulo 2^ADDR_W, no error.
REQ-027 Exactly N_ELEM accepted writes per job; addresses strictly increasing (mod 2^ADDR_W).
REQ-028 idx counter width ceil(log2(N_ELEM))+1, no overflow for any N_ELEM>=1.
REQ-029 N_ELEM=1: single write, then DONE.

Reset
REQ-030 i_rstn=0 asynchronously forces IDLE, idx=0, shadow=0, o_write_addr=0, o_write_data=0, o_write_en=0, o_busy=0, o_done=0.
REQ-031 Reset mid-job aborts: no further writes, no o_done; after release block waits in IDLE for a new i_start.

Verification
REQ-032 Nominal: N_ELEM=16, BASE_ADDR=0, vec elements k=0x1000+k, i_wr_ready=1, pulse i_start -> 16 consecutive writes addr 0..15 data 0x1000..0x100F, o_done one cycle after last write.
REQ-033 Stall: i_wr_ready=0 for 3 cycles while idx=5 -> addr 5/data 0x1005 held 3 cycles, written once, job ends 3 cycles later than nominal.
REQ-034 Wrap: BASE_ADDR=1020, ADDR_W=10 -> addresses 1020..1023 then 0..11.
REQ-035 Input isolation: change i_result_vec to all 0xFFFF one cycle after LOAD -> written data still 0x1000+k; i_start held high throughout -> second job starts only after return to IDLE.
REQ-036 Reset abort: assert i_rstn=0 after 7th accepted write -> o_write_en=0 immediately, o_done never asserts, outputs all zero; new i_start after release writes full 16 elements from addr BASE_ADDR.
